// File: rtl/ahmes_pkg.sv
// Shared definitions for the Ahmes control unit: FSM states, instruction groups,
// ALU opcodes, flag positions and the EXEC-state decode helper.
package ahmes_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_F_MAR  = 4'd1,
      ST_F_RD   = 4'd2,
      ST_F_IR   = 4'd3,
      ST_DEC    = 4'd4,
      ST_A_MAR  = 4'd5,
      ST_A_RD   = 4'd6,
      ST_A_MAR2 = 4'd7,
      ST_D_RD   = 4'd8,
      ST_D_WR   = 4'd9,
      ST_EXEC   = 4'd10,
      ST_J_LD   = 4'd11,
      ST_J_SKIP = 4'd12
   } state_e;

   // Instruction groups (upper opcode nibble)
   localparam logic [3:0] GRP_NOP = 4'h0;
   localparam logic [3:0] GRP_STA = 4'h1;
   localparam logic [3:0] GRP_LDA = 4'h2;
   localparam logic [3:0] GRP_ADD = 4'h3;
   localparam logic [3:0] GRP_OR  = 4'h4;
   localparam logic [3:0] GRP_AND = 4'h5;
   localparam logic [3:0] GRP_NOT = 4'h6;
   localparam logic [3:0] GRP_SUB = 4'h7;
   localparam logic [3:0] GRP_JMP = 4'h8;
   localparam logic [3:0] GRP_JNV = 4'h9;
   localparam logic [3:0] GRP_JZ  = 4'hA;
   localparam logic [3:0] GRP_JCB = 4'hB;
   localparam logic [3:0] GRP_SHF = 4'hE;
   localparam logic [3:0] GRP_HLT = 4'hF;

   localparam logic [7:0] OP_SHR = 8'hE0;
   localparam logic [7:0] OP_SHL = 8'hE1;
   localparam logic [7:0] OP_ROR = 8'hE2;
   localparam logic [7:0] OP_ROL = 8'hE3;
   localparam logic [7:0] OP_HLT = 8'hF0;

   localparam logic [3:0] ALU_NOP = 4'b0000;
   localparam logic [3:0] ALU_ADD = 4'b0001;
   localparam logic [3:0] ALU_SUB = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_AND = 4'b0100;
   localparam logic [3:0] ALU_NOT = 4'b0101;
   localparam logic [3:0] ALU_ROL = 4'b0111;
   localparam logic [3:0] ALU_ROR = 4'b1000;
   localparam logic [3:0] ALU_SHL = 4'b1001;
   localparam logic [3:0] ALU_SHR = 4'b1010;

   localparam int unsigned FLAG_N = 4;
   localparam int unsigned FLAG_Z = 3;
   localparam int unsigned FLAG_V = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_B = 0;

   localparam logic [4:0] FL_NONE = 5'b00000;
   localparam logic [4:0] FL_NZ   = 5'b11000;
   localparam logic [4:0] FL_NZVC = 5'b11110;
   localparam logic [4:0] FL_NZVB = 5'b11101;
   localparam logic [4:0] FL_NZC  = 5'b11010;

   typedef struct packed {
      logic       ac_ld;
      logic       ac_sel;
      logic [3:0] alu_op;
      logic [4:0] flag_ld;
      logic       use_cin;
   } exec_ctl_t;

   function automatic logic is_mem_op(input logic [3:0] grp);
      logic r;
      case (grp)
         GRP_STA, GRP_LDA, GRP_ADD, GRP_OR, GRP_AND, GRP_SUB: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic is_jump(input logic [3:0] grp);
      logic r;
      case (grp)
         GRP_JMP, GRP_JNV, GRP_JZ, GRP_JCB: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // ac_ld is set only for instructions that finish in EXEC, so DEC reuses it
   function automatic exec_ctl_t exec_decode(input logic [7:0] op);
      exec_ctl_t c;
      c.ac_ld   = 1'b0;
      c.ac_sel  = 1'b0;
      c.alu_op  = ALU_NOP;
      c.flag_ld = FL_NONE;
      c.use_cin = 1'b0;
      case (op[7:4])
         GRP_LDA: begin c.ac_ld = 1'b1; c.ac_sel = 1'b1; c.flag_ld = FL_NZ; end
         GRP_ADD: begin c.ac_ld = 1'b1; c.alu_op = ALU_ADD; c.flag_ld = FL_NZVC; end
         GRP_SUB: begin c.ac_ld = 1'b1; c.alu_op = ALU_SUB; c.flag_ld = FL_NZVB; end
         GRP_OR:  begin c.ac_ld = 1'b1; c.alu_op = ALU_OR;  c.flag_ld = FL_NZ; end
         GRP_AND: begin c.ac_ld = 1'b1; c.alu_op = ALU_AND; c.flag_ld = FL_NZ; end
         GRP_NOT: begin c.ac_ld = 1'b1; c.alu_op = ALU_NOT; c.flag_ld = FL_NZ; end
         GRP_SHF: begin
            case (op)
               OP_SHR: begin c.ac_ld = 1'b1; c.alu_op = ALU_SHR; c.flag_ld = FL_NZC; end
               OP_SHL: begin c.ac_ld = 1'b1; c.alu_op = ALU_SHL; c.flag_ld = FL_NZC; end
               OP_ROR: begin c.ac_ld = 1'b1; c.alu_op = ALU_ROR; c.flag_ld = FL_NZC; c.use_cin = 1'b1; end
               OP_ROL: begin c.ac_ld = 1'b1; c.alu_op = ALU_ROL; c.flag_ld = FL_NZC; c.use_cin = 1'b1; end
               default: c.ac_ld = 1'b0;
            endcase
         end
         default: c.ac_ld = 1'b0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/ahmes_control_if.sv
// Program-memory request/ready handshake between the control unit and memory.
interface ahmes_control_if;
   logic mem_req;
   logic mem_we;
   logic mem_ready;

   modport master (output mem_req, output mem_we, input mem_ready);
   modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/ahmes_branch_eval.sv
// Combinational branch condition: JMP always taken, conditional jumps test one
// stored flag selected by opcode bits [3:2]; undefined sub-codes are not taken.
module ahmes_branch_eval
   import ahmes_pkg::*;
(
   input  logic [7:0] ir_opcode,
   input  logic [4:0] flags,
   output logic       take_branch
);

   logic unused_s;
   assign unused_s = ^ir_opcode[1:0];

   // Select the flag (or its complement) tested by the current jump
   always_comb begin
      take_branch = 1'b0;
      case (ir_opcode[7:4])
         GRP_JMP: take_branch = 1'b1;
         GRP_JNV: begin
            case (ir_opcode[3:2])
               2'b00:   take_branch = flags[FLAG_N];
               2'b01:   take_branch = ~flags[FLAG_N];
               2'b10:   take_branch = flags[FLAG_V];
               2'b11:   take_branch = ~flags[FLAG_V];
               default: take_branch = 1'b0;
            endcase
         end
         GRP_JZ: begin
            case (ir_opcode[3:2])
               2'b00:   take_branch = flags[FLAG_Z];
               2'b01:   take_branch = ~flags[FLAG_Z];
               default: take_branch = 1'b0;
            endcase
         end
         GRP_JCB: begin
            case (ir_opcode[3:2])
               2'b00:   take_branch = flags[FLAG_C];
               2'b01:   take_branch = ~flags[FLAG_C];
               2'b10:   take_branch = flags[FLAG_B];
               2'b11:   take_branch = ~flags[FLAG_B];
               default: take_branch = 1'b0;
            endcase
         end
         default: take_branch = 1'b0;
      endcase
   end

endmodule

// File: rtl/ahmes_control.sv
// Ahmes control unit: fetch/decode/execute FSM that is the only source of
// datapath strobes and drives the program-memory req/ready handshake.
module ahmes_control
   import ahmes_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [7:0]             ir_opcode,
   input  logic [4:0]             flags,
   ahmes_control_if.master        mem,
   output logic                   mar_ld,
   output logic                   mar_sel,
   output logic                   mdr_ld,
   output logic                   mdr_sel,
   output logic                   pc_inc,
   output logic                   pc_ld,
   output logic                   ir_ld,
   output logic                   ac_ld,
   output logic                   ac_sel,
   output logic [3:0]             alu_op,
   output logic                   alu_cin,
   output logic [4:0]             flag_ld,
   output logic                   halted
);

   state_e    state_r;
   state_e    next_s;
   logic      take_s;
   logic      mem_req_s;
   logic      mem_we_s;
   logic [3:0] grp_s;
   exec_ctl_t exec_s;

   assign grp_s  = ir_opcode[7:4];
   assign exec_s = exec_decode(ir_opcode);

   ahmes_branch_eval u_branch (
      .ir_opcode   (ir_opcode),
      .flags       (flags),
      .take_branch (take_s)
   );

   // State register; reset is asynchronous so mem_req drops immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state and strobe decode; mem_ready only matters in request states
   always_comb begin
      next_s    = state_r;
      mem_req_s = 1'b0;
      mem_we_s  = 1'b0;
      mar_ld    = 1'b0;
      mar_sel   = 1'b0;
      mdr_ld    = 1'b0;
      mdr_sel   = 1'b0;
      pc_inc    = 1'b0;
      pc_ld     = 1'b0;
      ir_ld     = 1'b0;
      ac_ld     = 1'b0;
      ac_sel    = 1'b0;
      alu_op    = ALU_NOP;
      alu_cin   = 1'b0;
      flag_ld   = FL_NONE;
      halted    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            halted = 1'b1;
            if (start) next_s = ST_F_MAR;
            else       next_s = ST_IDLE;
         end
         ST_F_MAR: begin
            mar_ld = 1'b1;
            next_s = ST_F_RD;
         end
         ST_F_RD: begin
            mem_req_s = 1'b1;
            if (mem.mem_ready) begin
               mdr_ld = 1'b1;
               pc_inc = 1'b1;
               next_s = ST_F_IR;
            end else begin
               next_s = ST_F_RD;
            end
         end
         ST_F_IR: begin
            ir_ld  = 1'b1;
            next_s = ST_DEC;
         end
         ST_DEC: begin
            if (is_mem_op(grp_s))    next_s = ST_A_MAR;
            else if (is_jump(grp_s)) next_s = take_s ? ST_A_MAR : ST_J_SKIP;
            else if (exec_s.ac_ld)   next_s = ST_EXEC;
            else if (ir_opcode == OP_HLT) next_s = ST_IDLE;
            else                     next_s = ST_F_MAR;
         end
         ST_A_MAR: begin
            mar_ld = 1'b1;
            next_s = ST_A_RD;
         end
         ST_A_RD: begin
            mem_req_s = 1'b1;
            if (mem.mem_ready) begin
               mdr_ld = 1'b1;
               pc_inc = 1'b1;
               next_s = is_jump(grp_s) ? ST_J_LD : ST_A_MAR2;
            end else begin
               next_s = ST_A_RD;
            end
         end
         ST_A_MAR2: begin
            // STA: MAR takes the operand address while MDR takes AC on the same edge
            mar_ld  = 1'b1;
            mar_sel = 1'b1;
            if (grp_s == GRP_STA) begin
               mdr_ld  = 1'b1;
               mdr_sel = 1'b1;
               next_s  = ST_D_WR;
            end else begin
               next_s  = ST_D_RD;
            end
         end
         ST_D_RD: begin
            mem_req_s = 1'b1;
            if (mem.mem_ready) begin
               mdr_ld = 1'b1;
               next_s = ST_EXEC;
            end else begin
               next_s = ST_D_RD;
            end
         end
         ST_D_WR: begin
            mem_req_s = 1'b1;
            mem_we_s  = 1'b1;
            if (mem.mem_ready) next_s = ST_F_MAR;
            else               next_s = ST_D_WR;
         end
         ST_EXEC: begin
            ac_ld   = exec_s.ac_ld;
            ac_sel  = exec_s.ac_sel;
            alu_op  = exec_s.alu_op;
            flag_ld = exec_s.flag_ld;
            alu_cin = exec_s.use_cin ? flags[FLAG_C] : 1'b0;
            next_s  = ST_F_MAR;
         end
         ST_J_LD: begin
            pc_ld  = 1'b1;
            next_s = ST_F_MAR;
         end
         ST_J_SKIP: begin
            pc_inc = 1'b1;
            next_s = ST_F_MAR;
         end
         default: next_s = ST_IDLE;
      endcase
   end

   assign mem.mem_req = mem_req_s;
   assign mem.mem_we  = mem_we_s;

endmodule
